bk_sum_stage: RTL and testbench

- Final stage of the 4-bit Brent-Kung adder/ALU. Sits directly downstream of the prefix tree of black and gray cells.
- Consumes the per-bit propagate vector and the prefix group-generate (carry) vector that the tree produces.
- Forms the sum bits and status flags (carry-out, overflow, zero, negative).
- Registers results into a 2-entry output buffer with valid/ready handshaking toward the result consumer.

---
 rtl/bk_sum_stage_if.sv | 29 ++
 rtl/bk_sum_stage.sv | 106 ++++++++++
 tb/tb_bk_sum_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_sum_stage_if.sv
// Handshake and data bundle between the prefix tree, the sum stage and the result consumer.
// master = upstream/consumer side, slave = the sum stage itself.
interface bk_sum_stage_if #(
  parameter int unsigned W = 4
) ();
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] Pi;
  logic [W-1:0] Gk;
  logic         Cin;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         Zero;
  logic         Neg;
  logic [1:0]   Count;

  modport master (
    output In_Valid, Pi, Gk, Cin, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Cout, Ovf, Zero, Neg, Count
  );

  modport slave (
    input  In_Valid, Pi, Gk, Cin, Out_Ready,
    output In_Ready, Out_Valid, Sum, Cout, Ovf, Zero, Neg, Count
  );
endinterface

// File: rtl/bk_sum_stage.sv
// Brent-Kung adder final stage: sum bits and flags from P/Gk, buffered in a 2-entry FIFO.
// Optional macro BK_STICKY_OVF_EN adds a sticky overflow flag (Ovf_Sticky) with clear (Ovf_Clr).
module bk_sum_stage #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  bk_sum_stage_if.slave bus
`ifdef BK_STICKY_OVF_EN
  ,
  input  logic          Ovf_Clr,
  output logic          Ovf_Sticky
`endif
);

  localparam int unsigned RecW = W + 4;
  localparam logic [1:0] CntFull = 2'(DEPTH);
  // Reset record: Sum=0, Cout=0, Ovf=0, Zero=1, Neg=0.
  localparam logic [RecW-1:0] RecRst = {{W{1'b0}}, 4'b0010};

  logic [W-1:0]    sum;
  logic [RecW-1:0] rec_in;
  logic [RecW-1:0] head;
  logic [RecW-1:0] mem_q [2];
  logic [RecW-1:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            push, pop;

  always_comb begin
    sum    = bus.Pi ^ {bus.Gk[W-2:0], bus.Cin};
    rec_in = {sum, bus.Gk[W-1], bus.Gk[W-1] ^ bus.Gk[W-2], ~|sum, sum[W-1]};
  end

  always_comb begin
    bus.In_Ready  = (count_q != CntFull);
    bus.Out_Valid = (count_q != 2'd0);
    bus.Count     = count_q;
    head          = mem_q[rd_ptr_q];
    {bus.Sum, bus.Cout, bus.Ovf, bus.Zero, bus.Neg} = head;
  end

  always_comb begin
    push     = bus.In_Valid & bus.In_Ready;
    pop      = bus.Out_Valid & bus.Out_Ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = rec_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= RecRst;
      mem_q[1] <= RecRst;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef BK_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set beats clear when both land in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (Ovf_Clr) begin
      sticky_d = 1'b0;
    end
    if (pop && head[2]) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign Ovf_Sticky = sticky_q;
`endif

endmodule

// File: tb/tb_bk_sum_stage.sv
// Scoreboard bench for bk_sum_stage: operands drive P/Gk via a ripple model, results checked in order.
module tb_bk_sum_stage;
  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] sb[$];

  bk_sum_stage_if #(.W(W)) bus ();

`ifdef BK_STICKY_OVF_EN
  logic Ovf_Clr;
  logic Ovf_Sticky;
`endif

  bk_sum_stage #(.W(W), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BK_STICKY_OVF_EN
    ,
    .Ovf_Clr    (Ovf_Clr),
    .Ovf_Sticky (Ovf_Sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference record {Sum, Cout, Ovf, Zero, Neg} from plain integer addition.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    logic       ovf;
    s   = 5'(a) + 5'(b) + 5'(c);
    ovf = (a[3] == b[3]) && (s[3] != a[3]);
    return {s[3:0], s[4], ovf, (s[3:0] == 4'd0), s[3]};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.Sum, bus.Cout, bus.Ovf, bus.Zero, bus.Neg};
  endfunction

  // What the prefix tree would present for A+B+Cin.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic       cy;
    logic [3:0] gk;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      cy    = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
      gk[i] = cy;
    end
    bus.In_Valid = v;
    bus.Pi       = a ^ b;
    bus.Gk       = gk;
    bus.Cin      = c;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    bus.Out_Ready = 1'b0;
    apply_reset();
    n_checks++;
    if (bus.Out_Valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.Out_Valid);
    end
    n_checks++;
    if (bus.In_Ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.In_Ready);
    end
    n_checks++;
    if (bus.Count !== 2'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.Count);
    end
    n_checks++;
    if (obs() !== 8'b0000_0010) begin
      n_errors++; $display("FAIL reset_record: got %b expected 00000010", obs());
    end
  endtask

  // One push into an empty buffer per pattern; result visible next cycle, gone the one after.
  task automatic test_arith();
    logic [3:0] ta [6] = '{4'h5, 4'hF, 4'h7, 4'h8, 4'h9, 4'h0};
    logic [3:0] tb [6] = '{4'h3, 4'h1, 4'h0, 4'h8, 4'hE, 4'h0};
    logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp;
    bus.Out_Ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, ta[k], tb[k], tc[k]);
      n_checks++;
      if (bus.In_Ready !== 1'b1) begin
        n_errors++; $display("FAIL arith_in_ready[%0d]: got %b expected 1", k, bus.In_Ready);
      end
      sb.push_back(model(ta[k], tb[k], tc[k]));
      @(negedge clk);
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      n_checks++;
      if (bus.Out_Valid !== 1'b1 || bus.Count !== 2'd1) begin
        n_errors++;
        $display("FAIL arith_valid[%0d]: got valid %b count %0d expected 1/1", k, bus.Out_Valid,
                 bus.Count);
      end
      exp = sb.pop_front();
      n_checks++;
      if (obs() !== exp) begin
        n_errors++; $display("FAIL arith_record[%0d]: got %b expected %b", k, obs(), exp);
      end
      @(negedge clk);
      n_checks++;
      if (bus.Out_Valid !== 1'b0 || $isunknown(obs())) begin
        n_errors++; $display("FAIL arith_drain[%0d]: got valid %b rec %b expected 0, no X", k,
                             bus.Out_Valid, obs());
      end
    end
  endtask

  // Fill with Out_Ready low, third offer held off until space opens.
  task automatic test_full();
    logic       tv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] ta [7] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0};
    logic       tr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       do_pop, do_push;
    for (int k = 0; k < 7; k++) begin
      drive(tv[k], ta[k], ta[k], 1'b0);
      bus.Out_Ready = tr[k];
      do_pop  = tr[k] && (sb.size() != 0);
      do_push = tv[k] && (sb.size() != 2);
      n_checks++;
      if (bus.Count !== 2'(sb.size())) begin
        n_errors++; $display("FAIL full_count[%0d]: got %0d expected %0d", k, bus.Count, sb.size());
      end
      n_checks++;
      if ({bus.In_Ready, bus.Out_Valid} !== {sb.size() != 2, sb.size() != 0}) begin
        n_errors++; $display("FAIL full_hs[%0d]: got rdy/vld %b%b expected %b%b", k, bus.In_Ready,
                             bus.Out_Valid, sb.size() != 2, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        n_checks++;
        if (obs() !== sb[0]) begin
          n_errors++; $display("FAIL full_head[%0d]: got %b expected %b", k, obs(), sb[0]);
        end
      end
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(model(ta[k], ta[k], 1'b0));
      @(negedge clk);
    end
  endtask

  // Push and pop together at Count=1: occupancy holds, pushed record becomes head.
  task automatic test_simul();
    logic       tv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ta [6] = '{4'd4, 4'd6, 4'hA, 4'd0, 4'd0, 4'd0};
    logic [3:0] tb [6] = '{4'd5, 4'd6, 4'hB, 4'd0, 4'd0, 4'd0};
    logic       tr [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       do_pop, do_push;
    for (int k = 0; k < 6; k++) begin
      drive(tv[k], ta[k], tb[k], 1'b0);
      bus.Out_Ready = tr[k];
      do_pop  = tr[k] && (sb.size() != 0);
      do_push = tv[k] && (sb.size() != 2);
      n_checks++;
      if (bus.Count !== 2'(sb.size())) begin
        n_errors++; $display("FAIL simul_count[%0d]: got %0d expected %0d", k, bus.Count, sb.size());
      end
      n_checks++;
      if ({bus.In_Ready, bus.Out_Valid} !== {sb.size() != 2, sb.size() != 0}) begin
        n_errors++; $display("FAIL simul_hs[%0d]: got rdy/vld %b%b expected %b%b", k, bus.In_Ready,
                             bus.Out_Valid, sb.size() != 2, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        n_checks++;
        if (obs() !== sb[0]) begin
          n_errors++; $display("FAIL simul_head[%0d]: got %b expected %b", k, obs(), sb[0]);
        end
      end
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(model(ta[k], tb[k], 1'b0));
      @(negedge clk);
    end
  endtask

  // Asynchronous reset while full, then confirm only fresh data emerges.
  task automatic test_reset_mid();
    logic [7:0] exp;
    bus.Out_Ready = 1'b0;
    drive(1'b1, 4'd7, 4'd7, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.Count !== 2'd2) begin
      n_errors++; $display("FAIL midrst_fill: got %0d expected 2", bus.Count);
    end
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({bus.Out_Valid, bus.In_Ready, bus.Count, bus.Zero} !== 5'b01001) begin
      n_errors++; $display("FAIL midrst_state: got vld %b rdy %b cnt %0d zero %b expected 0 1 0 1",
                           bus.Out_Valid, bus.In_Ready, bus.Count, bus.Zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.Out_Ready = 1'b1;
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    sb.push_back(model(4'd1, 4'd2, 1'b0));
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    exp = sb.pop_front();
    n_checks++;
    if (bus.Out_Valid !== 1'b1 || obs() !== exp) begin
      n_errors++; $display("FAIL midrst_fresh: got vld %b rec %b expected 1 %b", bus.Out_Valid,
                           obs(), exp);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.Out_Valid !== 1'b0) begin
        n_errors++; $display("FAIL midrst_stale: got valid %b expected 0", bus.Out_Valid);
      end
    end
  endtask

`ifdef BK_STICKY_OVF_EN
  task automatic test_sticky();
    logic [3:0] ta [3] = '{4'd5, 4'd1, 4'd5};
    logic [3:0] tb [3] = '{4'd3, 4'd1, 4'd3};
    logic       tclr [3] = '{1'b0, 1'b0, 1'b1};
    logic       exp;
    Ovf_Clr = 1'b0;
    apply_reset();
    exp = 1'b0;
    n_checks++;
    if (Ovf_Sticky !== exp) begin
      n_errors++; $display("FAIL sticky_reset: got %b expected 0", Ovf_Sticky);
    end
    bus.Out_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ta[k], tb[k], 1'b0);
      @(negedge clk);
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      Ovf_Clr = tclr[k];
      if (tclr[k]) exp = 1'b0;
      if (model(ta[k], tb[k], 1'b0) & 8'h04) exp = 1'b1;
      @(negedge clk);
      Ovf_Clr = 1'b0;
      n_checks++;
      if (Ovf_Sticky !== exp) begin
        n_errors++; $display("FAIL sticky_pop[%0d]: got %b expected %b", k, Ovf_Sticky, exp);
      end
    end
    Ovf_Clr = 1'b1;
    @(negedge clk);
    Ovf_Clr = 1'b0;
    n_checks++;
    if (Ovf_Sticky !== 1'b0) begin
      n_errors++; $display("FAIL sticky_clear: got %b expected 0", Ovf_Sticky);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
`ifdef BK_STICKY_OVF_EN
    Ovf_Clr = 1'b0;
`endif
    test_reset();
    test_arith();
    test_full();
    test_simul();
    test_reset_mid();
`ifdef BK_STICKY_OVF_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
